// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache.
//
// Sits between instruction fetch and the memory controller. Every hit returns
// a 32-bit word one cycle after the request is accepted. On a miss the whole
// 16-byte line is fetched, installed, and the requested word is returned one
// cycle after the fill arrives. Only one request is outstanding at a time.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_from_ifetch      fetch address (bits [1:0] ignored)
//   valid_from_ifetch   fetch request, held with a stable pc until ready
//   ready_to_ifetch     one-cycle pulse, inst_to_ifetch valid this cycle
//   inst_to_ifetch      returned instruction word
//   flush_from_rob      cancels the current fetch
//   addr_to_mem         line address of the outstanding fill
//   valid_to_mem        fill request, held until ready_from_mem
//   data_from_mem       filled line, byte k at bits [8k+7:8k]
//   ready_from_mem      one-cycle pulse, data_from_mem valid this cycle
module icache_direct #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pc_from_ifetch,
    input  logic         valid_from_ifetch,
    output logic         ready_to_ifetch,
    output logic [31:0]  inst_to_ifetch,
    input  logic         flush_from_rob,
    output logic [31:0]  addr_to_mem,
    output logic         valid_to_mem,
    input  logic [127:0] data_from_mem,
    input  logic         ready_from_mem
);

    localparam int TAG_WIDTH = 32 - 4 - INDEX_WIDTH;
    localparam int NUM_LINES = 1 << INDEX_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    // Word-granular view of a fetch address: pc[31:2] = {tag, index, word}.
    typedef struct packed {
        logic [TAG_WIDTH-1:0]   tag;
        logic [INDEX_WIDTH-1:0] index;
        logic [1:0]             word;
    } waddr_t;

    // Cache storage. Only the valid bits need a reset; tag/data contents are
    // meaningless until their valid bit is set by a fill.
    logic [NUM_LINES-1:0] line_valid;
    logic [TAG_WIDTH-1:0] tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    // Registered control state.
    state_t state;
    waddr_t miss_q;      // address captured at miss time, used for the whole miss
    logic   discard;     // fill still pending but its result must not be returned

    // Next-state values.
    state_t      state_d;
    waddr_t      miss_d;
    logic        discard_d;
    logic        ready_d;
    logic [31:0] inst_d;
    logic [31:0] addr_d;
    logic        vmem_d;
    logic        fill_we;

    // Lookup.
    waddr_t      req;
    logic        accept;
    logic        hit;
    logic [31:0] hit_word;
    logic [31:0] fill_word;

    // Byte offset within a word is irrelevant to an instruction cache.
    logic unused_pc_low;
    assign unused_pc_low = &{1'b0, pc_from_ifetch[1:0]};

    function automatic logic [31:0] pick_word(input logic [127:0] line,
                                              input logic [1:0]   sel);
        logic [31:0] w;
        case (sel)
            2'd0:    w = line[31:0];
            2'd1:    w = line[63:32];
            2'd2:    w = line[95:64];
            default: w = line[127:96];
        endcase
        return w;
    endfunction

    assign req       = pc_from_ifetch[31:2];
    // A cycle carrying a ready pulse never accepts, so a held request is
    // served once per accept rather than twice for the same response.
    assign accept    = valid_from_ifetch && !ready_to_ifetch && !flush_from_rob;
    assign hit       = line_valid[req.index] && (tag_mem[req.index] == req.tag);
    assign hit_word  = pick_word(data_mem[req.index], req.word);
    assign fill_word = pick_word(data_from_mem, miss_q.word);

    always_comb begin
        state_d   = state;
        miss_d    = miss_q;
        discard_d = discard;
        ready_d   = 1'b0;
        inst_d    = inst_to_ifetch;
        addr_d    = addr_to_mem;
        vmem_d    = valid_to_mem;
        fill_we   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        ready_d = 1'b1;
                        inst_d  = hit_word;
                    end else begin
                        vmem_d  = 1'b1;
                        addr_d  = {pc_from_ifetch[31:4], 4'b0000};
                        miss_d  = req;
                        state_d = MISS;
                    end
                end
            end
            MISS: begin
                if (ready_from_mem) begin
                    // The line is installed regardless of any flush; only the
                    // response to fetch is dropped. A flush arriving with the
                    // fill itself also suppresses the pulse.
                    fill_we   = 1'b1;
                    vmem_d    = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                    if (!discard && !flush_from_rob) begin
                        ready_d = 1'b1;
                        inst_d  = fill_word;
                    end
                end else if (flush_from_rob) begin
                    // Memory cannot abort the fill, so keep requesting and
                    // just remember not to answer fetch.
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            miss_q          <= '0;
            discard         <= 1'b0;
            ready_to_ifetch <= 1'b0;
            inst_to_ifetch  <= '0;
            addr_to_mem     <= '0;
            valid_to_mem    <= 1'b0;
            line_valid      <= '0;
        end else begin
            state           <= state_d;
            miss_q          <= miss_d;
            discard         <= discard_d;
            ready_to_ifetch <= ready_d;
            inst_to_ifetch  <= inst_d;
            addr_to_mem     <= addr_d;
            valid_to_mem    <= vmem_d;
            if (fill_we) begin
                line_valid[miss_q.index] <= 1'b1;
            end
        end
    end

    // Tag/data arrays: overwritten unconditionally on a fill (no replacement
    // choice in a direct-mapped cache).
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[miss_q.index]  <= miss_q.tag;
            data_mem[miss_q.index] <= data_from_mem;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: a driver issues fetches and pushes
// expected responses into queues, a monitor checks every ready pulse, and a
// memory responder checks every fill request and supplies line data.
module tb_icache_direct;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pc_from_ifetch;
    logic         valid_from_ifetch;
    logic         ready_to_ifetch;
    logic [31:0]  inst_to_ifetch;
    logic         flush_from_rob;
    logic [31:0]  addr_to_mem;
    logic         valid_to_mem;
    logic [127:0] data_from_mem;
    logic         ready_from_mem;

    always #5 clk = ~clk;

    icache_direct #(.INDEX_WIDTH(6)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_from_ifetch    (pc_from_ifetch),
        .valid_from_ifetch (valid_from_ifetch),
        .ready_to_ifetch   (ready_to_ifetch),
        .inst_to_ifetch    (inst_to_ifetch),
        .flush_from_rob    (flush_from_rob),
        .addr_to_mem       (addr_to_mem),
        .valid_to_mem      (valid_to_mem),
        .data_from_mem     (data_from_mem),
        .ready_from_mem    (ready_from_mem)
    );

    typedef struct {
        logic [31:0] word;
        int          cyc;    // expected cycle of the pulse, -1 = any
    } exp_t;

    exp_t        expq[$];
    logic [31:0] memq[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit long_delay = 0;
    bit abort_fill = 0;

    // Reference model: which memory line (pc[31:4]) each of the 64 sets holds.
    bit          mv  [64];
    logic [27:0] mla [64];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Backing memory contents as a function of line address and word.
    function automatic logic [31:0] mem_word(input logic [27:0] la, input int k);
        logic [31:0] x;
        if (la == 28'h0000100 && k == 2) return 32'h0051_0113;
        x = {4'h0, la};
        return (x * 32'h9E37_79B1) ^ (k * 32'h7F4A_7C15) ^ 32'h0000_0013;
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        return {mem_word(la, 3), mem_word(la, 2), mem_word(la, 1), mem_word(la, 0)};
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int idx;
        idx = int'(pc[9:4]);
        return mv[idx] && (mla[idx] == pc[31:4]);
    endfunction

    // Monitor: every ready pulse must match the head of the expectation queue.
    exp_t mon_e;
    always @(negedge clk) begin
        if (ready_to_ifetch === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready actual inst %h required no pulse (cycle %0d)",
                         inst_to_ifetch, cyc);
            end else begin
                mon_e = expq.pop_front();
                check("inst", inst_to_ifetch, mon_e.word);
                if (mon_e.cyc >= 0) check("hit_latency", cyc, mon_e.cyc);
            end
        end
    end

    // Memory responder: checks each request address and that the request is
    // held until answered, then returns the line after a random delay.
    initial begin
        logic [31:0] a;
        int          d;
        bit          aborted;
        ready_from_mem = 1'b0;
        data_from_mem  = '0;
        forever begin
            @(negedge clk);
            if (valid_to_mem === 1'b1) begin
                a = addr_to_mem;
                if (memq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual addr %h required no request", a);
                end else begin
                    check("mem_addr", a, memq.pop_front());
                end
                d = long_delay ? 30 : int'($urandom_range(0, 4));
                aborted = 0;
                for (int i = 0; i < d; i++) begin
                    @(negedge clk);
                    if (abort_fill) begin
                        aborted = 1;
                        break;
                    end
                    check("mem_hold_valid", {31'b0, valid_to_mem}, 32'd1);
                    check("mem_hold_addr", addr_to_mem, a);
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    ready_from_mem = 1'b1;
                    data_from_mem  = mem_line(a[31:4]);
                    @(posedge clk); #1;
                    ready_from_mem = 1'b0;
                    data_from_mem  = {$urandom, $urandom, $urandom, $urandom};
                    @(negedge clk);
                    check("mem_drop", {31'b0, valid_to_mem}, 32'd0);
                end
            end
        end
    end

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (valid_to_mem === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL miss_timeout actual valid_to_mem %b required 0 within 60 cycles", valid_to_mem);
        end
    endtask

    // mode 0: plain fetch; 1: flush in the accept cycle; 2: flush two cycles
    // into a miss; 3: valid held for five edges on a hit.
    task automatic fetch(input logic [31:0] pc, input int mode);
        bit          hit = m_hit(pc);
        logic [31:0] w   = mem_word(pc[31:4], int'(pc[3:2]));
        int          idx = int'(pc[9:4]);
        int          n   = (mode == 3 && hit) ? 5 : 1;
        @(posedge clk); #1;
        pc_from_ifetch    = pc;
        valid_from_ifetch = 1'b1;
        flush_from_rob    = (mode == 1);
        @(posedge clk); #1;
        if (mode == 1) begin
            valid_from_ifetch = 1'b0;
            flush_from_rob    = 1'b0;
            @(negedge clk);
            check("flush_accept_ready", {31'b0, ready_to_ifetch}, 32'd0);
            check("flush_accept_vmem", {31'b0, valid_to_mem}, 32'd0);
            return;
        end
        if (hit) begin
            // held valid: accepts at every other edge
            for (int i = 0; i < n; i += 2) expq.push_back('{w, cyc + i});
            repeat (n - 1) @(posedge clk);
            #1;
            valid_from_ifetch = 1'b0;
        end else begin
            memq.push_back({pc[31:4], 4'b0000});
            mv[idx]  = 1;
            mla[idx] = pc[31:4];
            if (mode != 2) expq.push_back('{w, -1});
            valid_from_ifetch = 1'b0;
            if (mode == 2) begin
                @(posedge clk); #1;
                flush_from_rob = 1'b1;
                @(posedge clk); #1;
                flush_from_rob = 1'b0;
            end
            wait_idle();
        end
    endtask

    task automatic reset_mid_miss(input logic [31:0] pc);
        long_delay = 1;
        memq.push_back({pc[31:4], 4'b0000});
        @(posedge clk); #1;
        pc_from_ifetch    = pc;
        valid_from_ifetch = 1'b1;
        @(posedge clk); #1;
        valid_from_ifetch = 1'b0;
        @(posedge clk); #1;
        abort_fill = 1;
        rst        = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_miss_vmem", {31'b0, valid_to_mem}, 32'd0);
        check("rst_miss_ready", {31'b0, ready_to_ifetch}, 32'd0);
        check("rst_miss_addr", addr_to_mem, 32'd0);
        abort_fill = 0;
        long_delay = 0;
        for (int i = 0; i < 64; i++) mv[i] = 0;
    endtask

    initial begin
        logic [31:0] pc;
        int          r;
        rst               = 1'b1;
        pc_from_ifetch    = '0;
        valid_from_ifetch = 1'b0;
        flush_from_rob    = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mv[i]  = 0;
            mla[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, ready_to_ifetch}, 32'd0);
        check("reset_vmem", {31'b0, valid_to_mem}, 32'd0);
        check("reset_addr", addr_to_mem, 32'd0);
        check("reset_inst", inst_to_ifetch, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fetch(32'h0000_1008, 0);   // cold miss, word2 = 0x00510113
        fetch(32'h0000_100C, 0);   // hit
        fetch(32'h0000_1000, 0);
        fetch(32'h0000_1400, 0);   // same set, evicts
        fetch(32'h0000_1000, 0);   // misses again
        fetch(32'h0000_2000, 2);   // flush during miss
        fetch(32'h0000_2004, 0);   // line still installed
        fetch(32'h0000_2008, 1);   // flush in accept cycle
        fetch(32'h0000_2008, 3);   // held valid across pulses
        fetch(32'h0000_1008, 0);
        reset_mid_miss(32'h0000_3000);
        fetch(32'h0000_1008, 0);   // must miss after reset

        for (int t = 0; t < 300; t++) begin
            pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4)
               | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) pc[31:28] = 4'hA;
            r = int'($urandom_range(0, 9));
            fetch(pc, (r < 3) ? r + 1 : 0);
        end

        repeat (10) @(negedge clk);
        check("exp_queue_drained", expq.size(), 32'd0);
        check("mem_queue_drained", memq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch unit (upstream) and the memory controller (downstream).
- Serves 32-bit instruction words to fetch.
- On a miss it requests a whole 16-byte line from the memory controller, installs the line, then returns the word.
- One outstanding request at a time. No write path.

Parameters:
INDEX_WIDTH, 6, log2 of the number of lines (default 64 lines x 16 B = 1 KiB)
TAG_WIDTH, 32-4-INDEX_WIDTH, tag bits stored per line (derived; not overridable)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
pc_from_ifetch  input  32  fetch address, word-aligned (bits [1:0] ignored)
valid_from_ifetch  input  1  fetch request; held with a stable pc until ready_to_ifetch
ready_to_ifetch  output  1  one-cycle pulse; inst_to_ifetch is valid this cycle
inst_to_ifetch  output  32  returned instruction word
flush_from_rob  input  1  cancels the current fetch (mispredict/exception)
addr_to_mem  output  32  line address {pc[31:4], 4'b0}
valid_to_mem  output  1  line-fill request; held until ready_from_mem
data_from_mem  input  128  filled line; byte k at bits [8k+7:8k]
ready_from_mem  input  1  one-cycle pulse; data_from_mem valid this cycle

Behaviour:
- Clock and reset: clk, synchronous active-high rst.
- Reset: all line valid bits cleared; state=IDLE; ready_to_ifetch=0; valid_to_mem=0; addr_to_mem=0; inst_to_ifetch=0; discard=0.
- A reset mid-miss drops the miss. The memory controller shares rst, so no stale ready_from_mem can arrive.
- Address split: offset=pc[3:0]; word select=pc[3:2]; index=pc[4+INDEX_WIDTH-1:4]; tag=pc[31:4+INDEX_WIDTH].
- Word k of a line = line[32k+31:32k], little-endian.
- All outputs are registered.

State IDLE:
- A request is accepted when valid_from_ifetch=1 && ready_to_ifetch=0 && flush_from_rob=0.
- The cycle carrying a ready pulse is never an accept cycle, so a held request is not served twice.
- Hit (line valid and tag equal):
  - Next cycle: ready_to_ifetch=1 and inst_to_ifetch=selected word.
  - Latency 1 cycle; throughput 1 hit per 2 cycles.
- Miss:
  - Next cycle: valid_to_mem=1, addr_to_mem={pc[31:4],4'b0}; the pc is captured internally; state -> MISS.

State MISS:
- valid_to_mem and addr_to_mem are held constant until ready_from_mem.
- On ready_from_mem, all updates are registered:
  - line[index] <= data_from_mem; tag and valid bit written.
  - valid_to_mem <= 0.
  - If discard=0: inst_to_ifetch <= word from data_from_mem, ready_to_ifetch <= 1.
  - discard <= 0; state -> IDLE.
- Fill-to-ready latency is 1 cycle after ready_from_mem.
- valid_to_mem is low in the cycle after ready_from_mem. It cannot be reasserted for at least 1 further cycle, because IDLE must accept first.

Flush:
- In IDLE: no acceptance that cycle.
- If a hit pulse would be issued next cycle, it is suppressed: ready_to_ifetch=0.
- In MISS: discard <= 1. The fill request is not withdrawn, since the memory controller cannot abort. The line is still installed, but no ready_to_ifetch pulse is issued.
- flush_from_rob together with ready_from_mem in the same cycle: the line is installed and no pulse is issued.
- ready_to_ifetch is never asserted in the cycle after flush_from_rob=1.

Other rules:
- Conflict: a fill overwrites the same-index line unconditionally; no replacement state.
- A change of pc while valid_from_ifetch is held is illegal. The cache uses the captured pc for the whole miss.
- valid_from_ifetch=0 in IDLE: no action; outputs hold, except ready_to_ifetch, which is a pulse.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch pc=0x0000_1008.
  - Required: valid_to_mem=1 with addr_to_mem=0x0000_1000 one cycle later.
  - Drive ready_from_mem with data_from_mem word2=0x0051_0113.
  - Required: next cycle ready_to_ifetch=1, inst_to_ifetch=0x0051_0113, valid_to_mem=0.
- Hit:
  - Stimulus: then fetch pc=0x0000_100C.
  - Required: ready_to_ifetch=1 exactly 1 cycle after acceptance with word3 of the stored line; valid_to_mem stays 0.
- Conflict eviction:
  - Stimulus: fetch 0x0000_1000, then 0x0000_1400 (same index, INDEX_WIDTH=6).
  - Required: both miss. A refetch of 0x0000_1000 misses again with addr_to_mem=0x0000_1000.
- Flush during miss:
  - Stimulus: miss on pc=0x0000_2000; flush_from_rob=1 two cycles later.
  - Required: valid_to_mem held until ready_from_mem; no ready_to_ifetch pulse. A subsequent fetch of 0x0000_2004 hits in 1 cycle.
- Flush on hit plus back-to-back:
  - Stimulus: pulse flush_from_rob in the acceptance cycle of a hit.
  - Required: no ready pulse. With valid_from_ifetch held high across a ready pulse, the request is served exactly once per accept.
- Reset mid-miss:
  - Stimulus: rst during MISS.
  - Required: next cycle valid_to_mem=0, ready_to_ifetch=0. The previously filled pc=0x0000_1008 now misses.
